// File: rtl/shift_step_seq.sv
// ---------------------------------------------------------------------------
// shift_step_seq
//   Command sequencer for an external combinational W-bit barrel shifter.
//   It accepts one shift command, drives the shifter inputs from registers and
//   feeds each shifter result back as the next input. This repeats for a
//   programmable number of passes. The final word is then held until the
//   downstream side takes it.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   in_ready depends only on the FSM state (IDLE). It does not depend on
//   in_valid. out_valid depends only on the FSM state (DONE). While out_valid
//   is 1 and out_ready is 0, out_data is held stable.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake
//   in_data             initial working word
//   in_shamt            shift amount applied on every pass
//   in_lr               0 = right, 1 = left
//   in_al               0 = logical, 1 = arithmetic
//   in_reps             number of shifter passes (0 = pass-through)
//   flush               synchronous abort of the command in flight
//   sh_din/sh_shamt/sh_lr/sh_al   registered drive to the shifter
//   sh_dout             shifter result (combinational from sh_*)
//   out_valid/out_ready result handshake
//   out_data            final word (the working register)
//   busy                high while a command is in RUN or DONE
// ---------------------------------------------------------------------------
module shift_step_seq #(
    parameter int W  = 8,
    parameter int SW = 3,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic [SW-1:0] in_shamt,
    input  logic          in_lr,
    input  logic          in_al,
    input  logic [CW-1:0] in_reps,
    input  logic          flush,
    output logic [W-1:0]  sh_din,
    output logic [SW-1:0] sh_shamt,
    output logic          sh_lr,
    output logic          sh_al,
    input  logic [W-1:0]  sh_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  work_q,  work_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [SW-1:0] shamt_q, shamt_d;
    logic          lr_q,    lr_d;
    logic          al_q,    al_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            shamt_q <= '0;
            lr_q    <= 1'b0;
            al_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            lr_q    <= lr_d;
            al_q    <= al_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        shamt_d = shamt_q;
        lr_d    = lr_q;
        al_d    = al_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    cnt_d   = in_reps;
                    shamt_d = in_shamt;
                    lr_d    = in_lr;
                    al_d    = in_al;
                    state_d = (in_reps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // One shifter pass per edge. cnt counts the passes still to do.
                work_d = sh_dout;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything. A command accepted in the same cycle is
        // dropped: the working word and op registers keep their old values.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            work_d  = work_q;
            shamt_d = shamt_q;
            lr_d    = lr_q;
            al_d    = al_q;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sh_din    = work_q;
    assign sh_shamt  = shamt_q;
    assign sh_lr     = lr_q;
    assign sh_al     = al_q;
    assign out_data  = work_q;

endmodule
